// File: rtl/mux_serializer.sv
// mux_serializer: 8-bit parallel-to-serial sequencer
// that steps the select of an 8:1 bit mux.
module mux_serializer #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          MSB_FIRST    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] word,
  output logic [2:0] sel,
  output logic       sout,
  output logic       sout_valid,
  output logic       last,
  output logic       busy
);

  localparam int unsigned CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] SEL_FIRST =
    MSB_FIRST ? 3'd7 : 3'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       word_q, word_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitn_q, bitn_d;

  logic shifting;
  logic cnt_end;
  logic bit_end;
  logic ready_core;
  logic accept;

  assign shifting = (state_q == SHIFT);
  assign cnt_end  = (cnt_q == CNT_MAX);
  assign bit_end  = (bitn_q == 3'd7);

  // rst_n only gates the visible ready; the flops
  // are already held by the async reset.
  assign ready_core =
    !shifting || (bit_end && cnt_end);
  assign accept = din_valid && ready_core;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_end && bit_end && !accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    din_ready  = rst_n && ready_core;
    sout_valid = shifting;
    busy       = shifting;
    last       = shifting && bit_end;
    sout       = shifting ? word_q[sel_q] : 1'b0;
    word       = word_q;
    sel        = sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= 8'h00;
      sel_q  <= 3'd0;
      cnt_q  <= '0;
      bitn_q <= 3'd0;
    end else begin
      word_q <= word_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      bitn_q <= bitn_d;
    end
  end

  always_comb begin
    word_d = word_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    bitn_d = bitn_q;
    unique case (1'b1)
      accept: begin
        word_d = din;
        sel_d  = SEL_FIRST;
        cnt_d  = '0;
        bitn_d = 3'd0;
      end
      (shifting && !cnt_end): begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      (shifting && cnt_end && !bit_end): begin
        cnt_d  = '0;
        bitn_d = bitn_q + 3'd1;
        sel_d  = MSB_FIRST ? sel_q - 3'd1
                           : sel_q + 3'd1;
      end
      default: begin
        if (shifting) begin
          cnt_d = '0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer: directed vectors on two configs,
// checked against a frame-position model every cycle.
module tb_mux_serializer;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0][7:0] din;
  logic [1:0]      dv;
  logic [1:0]      o_ready;
  logic [1:0][7:0] o_word;
  logic [1:0][2:0] o_sel;
  logic [1:0]      o_sout;
  logic [1:0]      o_sv;
  logic [1:0]      o_last;
  logic [1:0]      o_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_serializer #(
    .CLKS_PER_BIT(1),
    .MSB_FIRST(1'b0)
  ) u0 (
    .clk(clk),
    .rst_n(rst_n),
    .din(din[0]),
    .din_valid(dv[0]),
    .din_ready(o_ready[0]),
    .word(o_word[0]),
    .sel(o_sel[0]),
    .sout(o_sout[0]),
    .sout_valid(o_sv[0]),
    .last(o_last[0]),
    .busy(o_busy[0])
  );

  mux_serializer #(
    .CLKS_PER_BIT(4),
    .MSB_FIRST(1'b1)
  ) u1 (
    .clk(clk),
    .rst_n(rst_n),
    .din(din[1]),
    .din_valid(dv[1]),
    .din_ready(o_ready[1]),
    .word(o_word[1]),
    .sel(o_sel[1]),
    .sout(o_sout[1]),
    .sout_valid(o_sv[1]),
    .last(o_last[1]),
    .busy(o_busy[1])
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: a frame is just a cycle count k since
  // acceptance; bit position is k / CLKS_PER_BIT.
  bit         m_act [2];
  int         m_k   [2];
  logic [7:0] m_word[2];
  logic [2:0] m_isel[2];

  function automatic int cpb(input int d);
    return (d == 1) ? 4 : 1;
  endfunction

  function automatic bit msb(input int d);
    return (d == 1);
  endfunction

  function automatic bit m_rdy(input int d);
    return !m_act[d] || (m_k[d] == 8 * cpb(d) - 1);
  endfunction

  function automatic int m_pos(input int d);
    return m_k[d] / cpb(d);
  endfunction

  function automatic logic [2:0] e_sel(input int d);
    if (!m_act[d]) return m_isel[d];
    return msb(d) ? 3'(7 - m_pos(d)) : 3'(m_pos(d));
  endfunction

  function automatic logic e_sout(input int d);
    if (!m_act[d]) return 1'b0;
    return m_word[d][e_sel(d)];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_act[d]  <= 1'b0;
        m_k[d]    <= 0;
        m_word[d] <= 8'h00;
        m_isel[d] <= 3'd0;
      end else if (m_rdy(d) && dv[d]) begin
        m_act[d]  <= 1'b1;
        m_k[d]    <= 0;
        m_word[d] <= din[d];
      end else if (m_act[d]) begin
        if (m_k[d] == 8 * cpb(d) - 1) begin
          m_act[d]  <= 1'b0;
          m_isel[d] <= msb(d) ? 3'd0 : 3'd7;
        end else begin
          m_k[d] <= m_k[d] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d_ready", d), o_ready[d],
          rst_n && m_rdy(d));
      chk($sformatf("u%0d_word", d), o_word[d],
          m_word[d]);
      chk($sformatf("u%0d_sel", d), o_sel[d],
          e_sel(d));
      chk($sformatf("u%0d_sout", d), o_sout[d],
          e_sout(d));
      chk($sformatf("u%0d_valid", d), o_sv[d],
          m_act[d]);
      chk($sformatf("u%0d_busy", d), o_busy[d],
          m_act[d]);
      chk($sformatf("u%0d_last", d), o_last[d],
          m_act[d] && m_pos(d) == 7);
    end
  end

  logic [7:0]  cap;
  logic [15:0] cap2;
  int          vcnt;

  initial begin
    rst_n = 1'b0;
    din   = '0;
    dv    = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", o_ready[0], 0);
    chk("rst_word", o_word[0], 8'h00);
    chk("rst_valid", o_sv[0], 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", o_ready[0], 1);

    // A5 once, LSB-first, one clock per bit
    @(posedge clk);
    #1 din[0] = 8'hA5; dv[0] = 1'b1;
    @(posedge clk);
    #1 dv[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cap[c] = o_sout[0];
      chk("t1_sel", o_sel[0], c);
      chk("t1_last", o_last[0], c == 7);
      chk("t1_ready", o_ready[0], c == 7);
    end
    chk("t1_stream", cap, 8'hA5);
    @(negedge clk);
    chk("t1_idle_valid", o_sv[0], 0);
    chk("t1_idle_sout", o_sout[0], 0);

    // A5 then 3C back-to-back
    @(posedge clk);
    #1 din[0] = 8'hA5; dv[0] = 1'b1;
    @(posedge clk);
    #1 din[0] = 8'h3C;
    vcnt = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (c < 16) begin
        vcnt += int'(o_sv[0]);
        cap2[c] = o_sout[0];
      end
      if (c == 7) chk("t2_word_a", o_word[0], 8'hA5);
      if (c == 8) chk("t2_word_b", o_word[0], 8'h3C);
      if (c == 16) chk("t2_end", o_sv[0], 0);
      if (c < 16) begin
        @(posedge clk);
        #1;
        if (c == 7) dv[0] = 1'b0;
      end
    end
    chk("t2_vcnt", vcnt, 16);
    chk("t2_first", cap2[7:0], 8'hA5);
    chk("t2_second", cap2[15:8], 8'h3C);

    // MSB-first, four clocks per bit, 81
    @(posedge clk);
    #1 din[1] = 8'h81; dv[1] = 1'b1;
    @(posedge clk);
    #1 dv[1] = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      vcnt += int'(o_sv[1]);
      if (c < 32) begin
        chk("t3_sel", o_sel[1], 7 - c / 4);
        chk("t3_sout", o_sout[1], (c < 4) || (c >= 28));
      end
    end
    chk("t3_vcnt", vcnt, 32);

    // FF offered mid-frame of 00
    @(posedge clk);
    #1 din[0] = 8'h00; dv[0] = 1'b1;
    @(posedge clk);
    #1 dv[0] = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 8) chk("t4_word_hold", o_word[0], 8'h00);
      if (c >= 3 && c < 7)
        chk("t4_ready_low", o_ready[0], 0);
      if (c == 7) chk("t4_ready_end", o_ready[0], 1);
      if (c == 8) chk("t4_word_ff", o_word[0], 8'hFF);
      if (c < 8) begin
        @(posedge clk);
        #1;
        if (c == 2) begin
          din[0] = 8'hFF;
          dv[0]  = 1'b1;
        end
        if (c == 7) dv[0] = 1'b0;
      end
    end
    repeat (10) @(posedge clk);

    // async reset 3 bits into A5
    #1 din[0] = 8'hA5; dv[0] = 1'b1;
    @(posedge clk);
    #1 dv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", o_sv[0], 0);
    chk("t5_busy", o_busy[0], 0);
    chk("t5_last", o_last[0], 0);
    chk("t5_sout", o_sout[0], 0);
    chk("t5_word", o_word[0], 8'h00);
    chk("t5_sel", o_sel[0], 0);
    chk("t5_ready", o_ready[0], 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rel_ready", o_ready[0], 1);
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      vcnt += int'(o_sv[0]);
    end
    chk("t5_no_residue", vcnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
